box_plotter: RTL and testbench

//  Downstream pixel engine for the whack-a-mole game FSM. Takes a box-draw request
//  (top-left X/Y and colour) or a full-screen clear request and emits one pixel per clock
//  (X, Y, colour, plot strobe) to the VGA adapter. Reports busy/done so the FSM can sequence draws.

---
 rtl/box_plotter.sv | 176 +++++++++++++++++
 tb/tb_box_plotter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_plotter.sv
// Pixel engine for the whack-a-mole game: rasterises a fixed-size box or sweeps the whole
// screen to colour 0, emitting one registered pixel per clock with busy/done handshaking.
module box_plotter #(
  parameter int BOX_W    = 20,
  parameter int BOX_H    = 20,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic       clk,
  input  logic       reset_m,
  input  logic       iPlotBox,
  input  logic       iClear,
  input  logic [8:0] iStart_X,
  input  logic [7:0] iStart_Y,
  input  logic [2:0] iColour,
  output logic [8:0] oX,
  output logic [7:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  localparam logic [9:0] BOX_X_LAST = 10'(BOX_W - 1);
  localparam logic [8:0] BOX_Y_LAST = 9'(BOX_H - 1);
  localparam logic [9:0] SCR_X_LAST = 10'(SCREEN_W - 1);
  localparam logic [8:0] SCR_Y_LAST = 9'(SCREEN_H - 1);
  localparam logic [9:0] SCR_W      = 10'(SCREEN_W);
  localparam logic [8:0] SCR_H      = 9'(SCREEN_H);

  state_t     state, next_state;

  logic [9:0] cx, cx_nxt, cx_adv;
  logic [8:0] cy, cy_nxt, cy_adv;
  logic [8:0] x0, x0_nxt;
  logic [7:0] y0, y0_nxt;
  logic [2:0] col, col_nxt;

  logic [8:0] x_nxt;
  logic [7:0] y_nxt;
  logic [2:0] colour_nxt;
  logic       plot_nxt, busy_nxt, done_nxt;

  logic       box_last, scr_last;
  logic [9:0] box_x;
  logic [8:0] box_y;

  assign box_last = (cx == BOX_X_LAST) && (cy == BOX_Y_LAST);
  assign scr_last = (cx == SCR_X_LAST) && (cy == SCR_Y_LAST);

  // Box coordinates are formed one bit wider so off-screen pixels never wrap back on-screen.
  assign box_x = {1'b0, x0} + cx_adv;
  assign box_y = {1'b0, y0} + cy_adv;

  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (iClear)        next_state = CLEAR;
        else if (iPlotBox) next_state = DRAW;
      end
      DRAW:    if (box_last) next_state = DONE;
      CLEAR:   if (scr_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Column counter is the fast axis; its wrap point depends on whether a box or the screen is swept.
  always_comb begin
    cx_adv = cx + 10'd1;
    cy_adv = cy;
    if ((state == CLEAR && cx == SCR_X_LAST) || (state != CLEAR && cx == BOX_X_LAST)) begin
      cx_adv = '0;
      cy_adv = cy + 9'd1;
    end
  end

  // Computes the pixel to present after the coming edge; the counters always name the pixel on the outputs.
  always_comb begin
    cx_nxt     = cx;
    cy_nxt     = cy;
    x0_nxt     = x0;
    y0_nxt     = y0;
    col_nxt    = col;
    x_nxt      = oX;
    y_nxt      = oY;
    colour_nxt = oColour;
    plot_nxt   = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (iClear) begin
          cx_nxt     = '0;
          cy_nxt     = '0;
          x_nxt      = '0;
          y_nxt      = '0;
          colour_nxt = '0;
          plot_nxt   = 1'b1;
        end else if (iPlotBox) begin
          cx_nxt     = '0;
          cy_nxt     = '0;
          x0_nxt     = iStart_X;
          y0_nxt     = iStart_Y;
          col_nxt    = iColour;
          x_nxt      = iStart_X;
          y_nxt      = iStart_Y;
          colour_nxt = iColour;
          plot_nxt   = ({1'b0, iStart_X} < SCR_W) && ({1'b0, iStart_Y} < SCR_H);
        end
      end
      DRAW: begin
        if (box_last) begin
          done_nxt = 1'b1;
        end else begin
          cx_nxt     = cx_adv;
          cy_nxt     = cy_adv;
          x_nxt      = box_x[8:0];
          y_nxt      = box_y[7:0];
          colour_nxt = col;
          plot_nxt   = (box_x < SCR_W) && (box_y < SCR_H);
        end
      end
      CLEAR: begin
        if (scr_last) begin
          done_nxt = 1'b1;
        end else begin
          cx_nxt     = cx_adv;
          cy_nxt     = cy_adv;
          x_nxt      = cx_adv[8:0];
          y_nxt      = cy_adv[7:0];
          colour_nxt = '0;
          plot_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) begin
      cx      <= '0;
      cy      <= '0;
      x0      <= '0;
      y0      <= '0;
      col     <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      cx      <= cx_nxt;
      cy      <= cy_nxt;
      x0      <= x0_nxt;
      y0      <= y0_nxt;
      col     <= col_nxt;
      oX      <= x_nxt;
      oY      <= y_nxt;
      oColour <= colour_nxt;
      oPlot   <= plot_nxt;
      oBusy   <= busy_nxt;
      oDone   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: expected pixels are queued when a request is driven and popped on each strobe.
module tb_box_plotter;

  localparam int BW = 20;
  localparam int BH = 20;
  localparam int SW = 320;
  // A shorter screen keeps the full clear sweeps cheap while exercising the same logic.
  localparam int SH = 64;
  localparam int NBOX = BW * BH;
  localparam int NSCR = SW * SH;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_m = 1'b1;
  logic       iPlotBox = 1'b0;
  logic       iClear = 1'b0;
  logic [8:0] iStart_X = '0;
  logic [7:0] iStart_Y = '0;
  logic [2:0] iColour = '0;
  logic [8:0] oX;
  logic [7:0] oY;
  logic [2:0] oColour;
  logic       oPlot, oBusy, oDone;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];

  box_plotter #(.BOX_W(BW), .BOX_H(BH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset_m(reset_m), .iPlotBox(iPlotBox), .iClear(iClear),
    .iStart_X(iStart_X), .iStart_Y(iStart_Y), .iColour(iColour),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  task automatic push_box(input int x0, input int y0, input int c);
    for (int yy = 0; yy < BH; yy++)
      for (int xx = 0; xx < BW; xx++)
        if (x0 + xx < SW && y0 + yy < SH)
          exp_q.push_back('{x: 9'(x0 + xx), y: 8'(y0 + yy), c: 3'(c)});
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back('{x: 9'(xx), y: 8'(yy), c: 3'd0});
  endtask

  task automatic request_box(input int x0, input int y0, input int c);
    @(negedge clk);
    iStart_X = 9'(x0);
    iStart_Y = 8'(y0);
    iColour  = 3'(c);
    iPlotBox = 1'b1;
    @(posedge clk);
    #1 iPlotBox = 1'b0;
  endtask

  task automatic test_reset();
    reset_m = 1'b1;
    #3 reset_m = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({oX, oY, oColour, oPlot, oBusy, oDone} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {oX, oY, oColour, oPlot, oBusy, oDone});
    end
    reset_m = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_box_basic();
    int strobes = 0, done_at = 0, busy_cnt = 0;
    pix_t e;
    exp_q.delete();
    push_box(134, 36, 7);
    request_box(134, 36, 7);
    for (int k = 1; k <= NBOX + 20; k++) begin
      @(negedge clk);
      if (oBusy) busy_cnt++;
      if (oPlot) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL box_extra_strobe: got (%0d,%0d) required no strobe", oX, oY);
        end else begin
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("[TB] FAIL box_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     strobes, oX, oY, oColour, e.x, e.y, e.c);
          end
        end
      end
      if (oDone && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 2) break;
    end
    checks++;
    if (strobes != NBOX || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL box_strobes: got %0d (left %0d) required %0d", strobes, exp_q.size(), NBOX);
    end
    checks++;
    if (done_at != NBOX + 1) begin
      errors++;
      $display("[TB] FAIL box_done_cycle: got %0d required %0d", done_at, NBOX + 1);
    end
    checks++;
    if (busy_cnt != NBOX + 1) begin
      errors++;
      $display("[TB] FAIL box_busy_cycles: got %0d required %0d", busy_cnt, NBOX + 1);
    end
    checks++;
    if ({oX, oY, oPlot, oBusy, oDone} !== {9'd153, 8'd55, 3'b000}) begin
      errors++;
      $display("[TB] FAIL box_idle_hold: got (%0d,%0d,%b%b%b) required (153,55,000)",
               oX, oY, oPlot, oBusy, oDone);
    end
  endtask

  task automatic test_clip();
    int strobes = 0, done_at = 0, busy_cnt = 0;
    pix_t e;
    exp_q.delete();
    push_box(310, SH - 10, 5);
    request_box(310, SH - 10, 5);
    for (int k = 1; k <= NBOX + 20; k++) begin
      @(negedge clk);
      if (oBusy) busy_cnt++;
      if (oPlot) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL clip_extra_strobe: got (%0d,%0d) required no strobe", oX, oY);
        end else begin
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("[TB] FAIL clip_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     strobes, oX, oY, oColour, e.x, e.y, e.c);
          end
        end
      end
      if (oDone && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 2) break;
    end
    checks++;
    if (strobes != 100 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL clip_strobes: got %0d (left %0d) required 100", strobes, exp_q.size());
    end
    checks++;
    if (done_at != NBOX + 1 || busy_cnt != NBOX + 1) begin
      errors++;
      $display("[TB] FAIL clip_timing: got done %0d busy %0d required %0d", done_at, busy_cnt, NBOX + 1);
    end
  endtask

  task automatic test_clear(input logic with_box);
    int strobes = 0, done_at = 0, busy_cnt = 0;
    pix_t e;
    exp_q.delete();
    push_clear();
    @(negedge clk);
    iStart_X = 9'd5;
    iStart_Y = 8'd5;
    iColour  = 3'd2;
    iPlotBox = with_box;
    iClear   = 1'b1;
    @(posedge clk);
    #1 iClear = 1'b0;
    iPlotBox = 1'b0;
    for (int k = 1; k <= NSCR + 20; k++) begin
      @(negedge clk);
      if (oBusy) busy_cnt++;
      if (oPlot) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL clear_extra_strobe: got (%0d,%0d) required no strobe", oX, oY);
        end else begin
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("[TB] FAIL clear_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     strobes, oX, oY, oColour, e.x, e.y, e.c);
          end
        end
      end
      if (oDone && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 2) break;
    end
    checks++;
    if (strobes != NSCR || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL clear_strobes: got %0d (left %0d) required %0d", strobes, exp_q.size(), NSCR);
    end
    checks++;
    if (done_at != NSCR + 1 || busy_cnt != NSCR + 1) begin
      errors++;
      $display("[TB] FAIL clear_timing: got done %0d busy %0d required %0d", done_at, busy_cnt, NSCR + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({oPlot, oBusy, oDone} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL clear_dropped_box: got plot/busy/done %b%b%b required 000", oPlot, oBusy, oDone);
    end
  endtask

  task automatic test_ignore_mid_draw();
    int strobes = 0, done_at = 0, busy_cnt = 0;
    pix_t e;
    exp_q.delete();
    push_box(134, 36, 7);
    request_box(134, 36, 7);
    for (int k = 1; k <= NBOX + 20; k++) begin
      @(negedge clk);
      if (k == 100) begin
        iStart_X = 9'd10;
        iStart_Y = 8'd10;
        iColour  = 3'd2;
        iPlotBox = 1'b1;
      end
      if (k == 104) iPlotBox = 1'b0;
      if (oBusy) busy_cnt++;
      if (oPlot) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL ignore_extra_strobe: got (%0d,%0d) required no strobe", oX, oY);
        end else begin
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("[TB] FAIL ignore_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     strobes, oX, oY, oColour, e.x, e.y, e.c);
          end
        end
      end
      if (oDone && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 2) break;
    end
    checks++;
    if (strobes != NBOX || exp_q.size() != 0 || done_at != NBOX + 1 || busy_cnt != NBOX + 1) begin
      errors++;
      $display("[TB] FAIL ignore_totals: got strobes %0d done %0d busy %0d required %0d/%0d/%0d",
               strobes, done_at, busy_cnt, NBOX, NBOX + 1, NBOX + 1);
    end
  endtask

  task automatic test_reset_mid_draw();
    int strobes = 0, done_at = 0, busy_cnt = 0;
    logic saw_done = 1'b0;
    pix_t e;
    exp_q.delete();
    push_box(134, 36, 7);
    request_box(134, 36, 7);
    for (int k = 1; k <= NBOX; k++) begin
      @(negedge clk);
      if (oPlot) begin
        strobes++;
        e = exp_q.pop_front();
      end
      if (strobes == 150) break;
    end
    #2 reset_m = 1'b0;
    #1;
    checks++;
    if ({oX, oY, oColour, oPlot, oBusy, oDone} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: got %h required 0", {oX, oY, oColour, oPlot, oBusy, oDone});
    end
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (oDone || oBusy || oPlot) saw_done = 1'b1;
    end
    reset_m = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (oDone || oBusy || oPlot) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abandon: got activity after reset required none");
    end
    strobes = 0;
    push_box(40, 36, 3);
    request_box(40, 36, 3);
    for (int k = 1; k <= NBOX + 20; k++) begin
      @(negedge clk);
      if (oBusy) busy_cnt++;
      if (oPlot) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL redraw_extra_strobe: got (%0d,%0d) required no strobe", oX, oY);
        end else begin
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("[TB] FAIL redraw_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     strobes, oX, oY, oColour, e.x, e.y, e.c);
          end
        end
      end
      if (oDone && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 2) break;
    end
    checks++;
    if (strobes != NBOX || exp_q.size() != 0 || done_at != NBOX + 1 || busy_cnt != NBOX + 1) begin
      errors++;
      $display("[TB] FAIL redraw_totals: got strobes %0d done %0d busy %0d required %0d/%0d/%0d",
               strobes, done_at, busy_cnt, NBOX, NBOX + 1, NBOX + 1);
    end
  endtask

  initial begin
    test_reset();
    test_box_basic();
    test_clip();
    test_clear(1'b0);
    test_clear(1'b1);
    test_ignore_mid_draw();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
